// File: rtl/ecc_pkg.sv
// Shared ECC definitions for the write-side encoder and read-side decoder.
// One parity definition so both ends of the memory path agree on the check field.
package ecc_pkg;

  localparam int DATA_W = 64;
  localparam int CHK_W  = 8;
  localparam int CODE_W = 72;
  localparam int NBYTES = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [NBYTES-1:0] bp;
    logic              inj;
  } s1_t;

  function automatic logic [CHK_W-1:0] ecc_parity(input logic [DATA_W-1:0] data);
    return {{(CHK_W-1){1'b0}}, ^data};
  endfunction

  // Byte parities let the second stage finish the reduction with an 8-input XOR.
  function automatic logic [NBYTES-1:0] byte_parity(input logic [DATA_W-1:0] data);
    logic [NBYTES-1:0] bp;
    bp = '0;
    for (int i = 0; i < NBYTES; i++) begin
      bp[i] = ^data[8*i +: 8];
    end
    return bp;
  endfunction

endpackage

// File: rtl/ecc_pipe_stage.sv
// Valid/ready register slice, one cycle latency; loads when empty or when downstream takes.
// Payload holds while stalled; ready is combinational from out_rdy_i.
module ecc_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         in_rdy_o,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o,
  input  logic         out_rdy_i
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;
  logic         load;

  assign load = !vld_q || out_rdy_i;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (load) begin
      vld_d = in_vld_i;
      if (in_vld_i) begin
        dat_d = in_dat_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign in_rdy_o  = load;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

endmodule

// File: rtl/ecc_encoder.sv
// Two-stage 64->72 parity encoder with one-shot parity corruption and a saturating handoff count.
// Latency two cycles; buffers two words under backpressure, in_ready follows out_ready combinationally.
module ecc_encoder
  import ecc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              inj_arm,
  output logic              inj_pending,
  output logic [CNT_W-1:0]  words_sent
);

  s1_t               s1_in;
  s1_t               s1_out;
  logic              s1_vld;
  logic              s2_rdy;
  logic [CHK_W-1:0]  s2_chk;
  logic [CODE_W-1:0] s2_in;
  logic              accept;
  logic              handoff;
  logic              inj_q, inj_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign accept  = in_valid && in_ready;
  assign handoff = out_valid && out_ready;

  always_comb begin
    s1_in.data = in_data;
    s1_in.bp   = byte_parity(in_data);
    s1_in.inj  = inj_q || inj_arm;
  end

  ecc_pipe_stage #(.W($bits(s1_t))) u_s1 (
    .clk_i     (sys_clk),
    .rst_n_i   (sys_rst_n),
    .in_vld_i  (in_valid),
    .in_dat_i  (s1_in),
    .in_rdy_o  (in_ready),
    .out_vld_o (s1_vld),
    .out_dat_o (s1_out),
    .out_rdy_i (s2_rdy)
  );

  // Parity of the byte parities equals parity of the whole word.
  assign s2_chk = ecc_parity({{(DATA_W-NBYTES){1'b0}}, s1_out.bp})
                ^ {{(CHK_W-1){1'b0}}, s1_out.inj};
  assign s2_in  = {s2_chk, s1_out.data};

  ecc_pipe_stage #(.W(CODE_W)) u_s2 (
    .clk_i     (sys_clk),
    .rst_n_i   (sys_rst_n),
    .in_vld_i  (s1_vld),
    .in_dat_i  (s2_in),
    .in_rdy_o  (s2_rdy),
    .out_vld_o (out_valid),
    .out_dat_o (out_data),
    .out_rdy_i (out_ready)
  );

  always_comb begin
    inj_d = inj_q;
    if (accept) begin
      inj_d = 1'b0;
    end else if (inj_arm) begin
      inj_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (handoff && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      inj_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      inj_q <= inj_d;
      cnt_q <= cnt_d;
    end
  end

  assign inj_pending = inj_q;
  assign words_sent  = cnt_q;

endmodule
